// File: rtl/char_blitter.sv
// char_blitter: scaled glyph renderer that walks a character's bounding box in raster order
// and streams one pixel per valid/ready beat towards the framebuffer writer.
module char_blitter #(
  parameter int unsigned  GLYPH_W    = 10,
  parameter int unsigned  GLYPH_H    = 10,
  parameter int unsigned  NUM_GLYPHS = 32,
  parameter int unsigned  COORD_W    = 8,
  parameter int unsigned  COLOUR_W   = 6,
  parameter int unsigned  SCALE_W    = 2,
  parameter               GLYPH_FILE = "glyphs.mem",
  localparam int unsigned CODE_W     = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic                ready,
  input  logic [CODE_W-1:0]   char_code,
  input  logic [COORD_W-1:0]  origin_x,
  input  logic [COORD_W-1:0]  origin_y,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic                opaque,
  input  logic [SCALE_W-1:0]  scale,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [COORD_W-1:0]  pix_x,
  output logic [COORD_W-1:0]  pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic                done
);

  localparam int unsigned SMAX  = (1 << SCALE_W) - 1;
  localparam int unsigned GX_W  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned GY_W  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int unsigned CX_W  = $clog2(GLYPH_W * SMAX + 1);
  localparam int unsigned CY_W  = $clog2(GLYPH_H * SMAX + 1);
  localparam int unsigned SUM_W = COORD_W + 1;

  // Bitmaps are compiled in; the file name is kept for flows that regenerate this table.
  localparam unused_glyph_file = GLYPH_FILE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SCAN,
    ST_DONE
  } state_t;

  // Glyph ROM: glyph 0 is the "X" glyph; other and out-of-range codes read blank.
  function automatic logic [GLYPH_W-1:0] glyph_row(input logic [CODE_W-1:0] code,
                                                   input logic [GY_W-1:0]   row);
    logic [GLYPH_W-1:0] bits;
    int unsigned        d;
    bits = '0;
    d    = (32'(row) * GLYPH_W) / GLYPH_H;
    if (32'(code) == 0 && 32'(code) < NUM_GLYPHS && 32'(row) < GLYPH_H) begin
      if (GLYPH_W == 10 && GLYPH_H == 10) begin
        case (32'(row))
          0, 1, 8, 9: bits = GLYPH_W'(32'h084);
          2, 7:       bits = GLYPH_W'(32'h0CC);
          3, 4, 6:    bits = GLYPH_W'(32'h048);
          5:          bits = GLYPH_W'(32'h030);
          default:    bits = '0;
        endcase
      end else begin
        bits = (GLYPH_W'(1) << d) | (GLYPH_W'(1) << (GLYPH_W - 1 - d));
      end
    end
    return bits;
  endfunction

  state_t                state_q, state_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic [COORD_W-1:0]    ox_q, ox_d, oy_q, oy_d;
  logic [COLOUR_W-1:0]   fg_q, fg_d, bg_q, bg_d;
  logic                  opq_q, opq_d;
  logic [SCALE_W-1:0]    s_q, s_d;
  logic [CX_W-1:0]       c_q, c_d;
  logic [CY_W-1:0]       r_q, r_d;
  logic [GX_W-1:0]       gx_q, gx_d;
  logic [GY_W-1:0]       gy_q, gy_d;
  logic [SCALE_W-1:0]    sx_q, sx_d, sy_q, sy_d;
  logic [GLYPH_W-1:0]    row_q, row_d;

  logic                  ready_d, valid_d, done_d;
  logic [COORD_W-1:0]    x_d, y_d;
  logic [COLOUR_W-1:0]   colour_d;

  logic                  load_pix, col_end, row_end, bit_set, clip;
  logic [SUM_W-1:0]      sum_x, sum_y;
  logic [SCALE_W-1:0]    s_last;

  assign s_last  = s_q - SCALE_W'(1);
  assign col_end = (gx_q == GX_W'(GLYPH_W - 1)) && (sx_q == s_last);
  assign row_end = (gy_q == GY_W'(GLYPH_H - 1)) && (sy_q == s_last);

  // Next-state and next-output logic; the pixel for the position being entered is
  // resolved here so every output leaves a flop.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    opq_d    = opq_q;
    s_d      = s_q;
    c_d      = c_q;
    r_d      = r_q;
    gx_d     = gx_q;
    gy_d     = gy_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    row_d    = row_q;
    valid_d  = pix_valid;
    x_d      = pix_x;
    y_d      = pix_y;
    colour_d = pix_colour;
    load_pix = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          code_d  = char_code;
          ox_d    = origin_x;
          oy_d    = origin_y;
          fg_d    = fg_colour;
          bg_d    = bg_colour;
          opq_d   = opaque;
          s_d     = (scale == '0) ? SCALE_W'(1) : scale;
          c_d     = '0;
          r_d     = '0;
          gx_d    = '0;
          gy_d    = '0;
          sx_d    = '0;
          sy_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        row_d    = glyph_row(code_q, gy_q);
        c_d      = '0;
        gx_d     = '0;
        sx_d     = '0;
        load_pix = 1'b1;
        state_d  = ST_SCAN;
      end
      ST_SCAN: begin
        // A pending beat holds everything until the downstream handshake.
        if (!pix_valid || pix_ready) begin
          if (col_end) begin
            valid_d = 1'b0;
            if (row_end) begin
              state_d = ST_DONE;
            end else begin
              r_d = r_q + CY_W'(1);
              if (sy_q == s_last) begin
                sy_d = '0;
                gy_d = gy_q + GY_W'(1);
              end else begin
                sy_d = sy_q + SCALE_W'(1);
              end
              state_d = ST_FETCH;
            end
          end else begin
            c_d = c_q + CX_W'(1);
            if (sx_q == s_last) begin
              sx_d = '0;
              gx_d = gx_q + GX_W'(1);
            end else begin
              sx_d = sx_q + SCALE_W'(1);
            end
            load_pix = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    // Positions past the screen edge carry out and are dropped like clear pixels.
    bit_set = row_d[gx_d];
    sum_x   = SUM_W'(ox_q) + SUM_W'(c_d);
    sum_y   = SUM_W'(oy_q) + SUM_W'(r_d);
    clip    = sum_x[COORD_W] | sum_y[COORD_W];
    if (load_pix) begin
      valid_d  = !clip && (bit_set || opq_q);
      x_d      = sum_x[COORD_W-1:0];
      y_d      = sum_y[COORD_W-1:0];
      colour_d = bit_set ? fg_q : bg_q;
    end

    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, request latches, counters and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      opq_q      <= 1'b0;
      s_q        <= SCALE_W'(1);
      c_q        <= '0;
      r_q        <= '0;
      gx_q       <= '0;
      gy_q       <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      row_q      <= '0;
      ready      <= 1'b1;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_colour <= '0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      opq_q      <= opq_d;
      s_q        <= s_d;
      c_q        <= c_d;
      r_q        <= r_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      row_q      <= row_d;
      ready      <= ready_d;
      pix_valid  <= valid_d;
      pix_x      <= x_d;
      pix_y      <= y_d;
      pix_colour <= colour_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_char_blitter.sv
// tb_char_blitter: table vectors, randomized requests against a raster-walk reference model,
// stall/start-while-busy and asynchronous reset sequences for char_blitter.
module tb_char_blitter;

  localparam int unsigned GW    = 10;
  localparam int unsigned GH    = 10;
  localparam int unsigned CODEW = 5;
  localparam int unsigned CW    = 8;
  localparam int unsigned COLW  = 6;
  localparam int unsigned SW    = 2;

  typedef struct packed {
    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic [COLW-1:0] col;
  } beat_t;

  typedef struct {
    int code;
    int ox;
    int oy;
    int fg;
    int bg;
    bit opq;
    int scale;
  } req_t;

  typedef struct {
    req_t rq;
    int   beats;
    int   lat;
    int   fx;
    int   fy;
    int   fcol;
    int   lx;
    int   ly;
    int   lcol;
  } vec_t;

  logic             clock = 1'b0;
  logic             resetn = 1'b1;
  logic             start = 1'b0;
  logic             ready;
  logic [CODEW-1:0] char_code = '0;
  logic [CW-1:0]    origin_x = '0;
  logic [CW-1:0]    origin_y = '0;
  logic [COLW-1:0]  fg_colour = '0;
  logic [COLW-1:0]  bg_colour = '0;
  logic             opaque = 1'b0;
  logic [SW-1:0]    scale = '0;
  logic             pix_valid;
  logic             pix_ready = 1'b1;
  logic [CW-1:0]    pix_x;
  logic [CW-1:0]    pix_y;
  logic [COLW-1:0]  pix_colour;
  logic             done;

  int    checks = 0;
  int    failures = 0;
  int    lat = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  vec_t  vecs[6];

  always #5 clock = ~clock;

  char_blitter #(
    .GLYPH_W(GW), .GLYPH_H(GH), .NUM_GLYPHS(32), .COORD_W(CW),
    .COLOUR_W(COLW), .SCALE_W(SW), .GLYPH_FILE("glyphs.mem")
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .ready(ready),
    .char_code(char_code), .origin_x(origin_x), .origin_y(origin_y),
    .fg_colour(fg_colour), .bg_colour(bg_colour), .opaque(opaque), .scale(scale),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_colour(pix_colour), .done(done)
  );

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference "X" bitmap, one set of lit columns per glyph row.
  function automatic logic [GW-1:0] glyph0_row(input int y);
    logic [GW-1:0] m;
    case (y)
      0, 1, 8, 9: m = (GW'(1) << 2) | (GW'(1) << 7);
      2, 7:       m = (GW'(1) << 2) | (GW'(1) << 3) | (GW'(1) << 6) | (GW'(1) << 7);
      3, 4, 6:    m = (GW'(1) << 3) | (GW'(1) << 6);
      5:          m = (GW'(1) << 4) | (GW'(1) << 5);
      default:    m = '0;
    endcase
    return m;
  endfunction

  // Expected beats: visit every magnified position in raster order.
  task automatic build_exp(input req_t rq);
    int            s;
    int            px;
    int            py;
    logic [GW-1:0] row;
    bit            b;
    s = (rq.scale == 0) ? 1 : rq.scale;
    exp_q.delete();
    for (int r = 0; r < int'(GH) * s; r++) begin
      row = (rq.code == 0) ? glyph0_row(r / s) : '0;
      for (int c = 0; c < int'(GW) * s; c++) begin
        b  = ((row >> (c / s)) & GW'(1)) != '0;
        px = rq.ox + c;
        py = rq.oy + r;
        if (px < (1 << CW) && py < (1 << CW) && (b || rq.opq))
          exp_q.push_back('{x: CW'(px), y: CW'(py), col: COLW'(b ? rq.fg : rq.bg)});
      end
    end
  endtask

  task automatic drive(input req_t rq);
    char_code = CODEW'(rq.code);
    origin_x  = CW'(rq.ox);
    origin_y  = CW'(rq.oy);
    fg_colour = COLW'(rq.fg);
    bg_colour = COLW'(rq.bg);
    opaque    = rq.opq;
    scale     = SW'(rq.scale);
  endtask

  // Called at a negedge; issues the request, collects beats until done, checks against model.
  task automatic run_req(input req_t rq, input bit stall, input bit spam);
    int    waited = 0;
    int    cyc = 0;
    int    bad = -1;
    int    s;
    bit    seen_done = 1'b0;
    bit    held = 1'b0;
    beat_t prev = '0;
    beat_t cur;
    build_exp(rq);
    got_q.delete();
    while (!ready && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    chk("ready_at_request", int'(ready), 1);
    drive(rq);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!seen_done && cyc < 8000) begin
      @(negedge clock);
      cyc++;
      cur = '{x: pix_x, y: pix_y, col: pix_colour};
      if (held) chk("stall_hold", int'(pix_valid && cur == prev), 1);
      held = pix_valid && !pix_ready;
      prev = cur;
      if (pix_valid && pix_ready) got_q.push_back(cur);
      if (done) begin
        seen_done = 1'b1;
      end else begin
        @(posedge clock);
        #1;
        pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (spam) begin
          start     = 1'($urandom_range(0, 1));
          char_code = CODEW'($urandom_range(1, 31));
          origin_x  = CW'($urandom);
          origin_y  = CW'($urandom);
          opaque    = 1'($urandom_range(0, 1));
        end
      end
    end
    start     = 1'b0;
    pix_ready = 1'b1;
    lat       = cyc;
    chk("done_seen", int'(seen_done), 1);
    s = (rq.scale == 0) ? 1 : rq.scale;
    if (!stall) chk("done_latency", cyc, int'(GH) * s * (1 + int'(GW) * s) + 1);
    chk("beat_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL beat_order: beat %0d got (%0d,%0d) colour %0d expected (%0d,%0d) colour %0d",
               bad, got_q[bad].x, got_q[bad].y, got_q[bad].col,
               exp_q[bad].x, exp_q[bad].y, exp_q[bad].col);
    end
    @(negedge clock);
    chk("done_pulse_width", int'(done), 0);
    chk("ready_after_done", int'(ready), 1);
  endtask

  initial begin
    req_t rq;
    int   found;
    int   waited;

    vecs[0] = '{'{0, 20, 30, 42, 21, 1'b0, 1}, 24, 111, 22, 30, 42, 27, 39, 42};
    vecs[1] = '{'{0, 20, 30, 63, 1, 1'b1, 1}, 100, 111, 20, 30, 1, 29, 39, 1};
    vecs[2] = '{'{0, 20, 30, 42, 21, 1'b0, 2}, 96, 421, 24, 30, 42, 35, 49, 42};
    vecs[3] = '{'{0, 250, 250, 12, 5, 1'b0, 1}, 8, 111, 252, 250, 12, 255, 255, 12};
    vecs[4] = '{'{0, 0, 0, 17, 3, 1'b0, 0}, 24, 111, 2, 0, 17, 7, 9, 17};
    vecs[5] = '{'{0, 100, 200, 7, 9, 1'b0, 3}, 216, 931, 106, 200, 7, 123, 229, 7};

    #2 resetn = 1'b0;
    #1;
    chk("reset_ready", int'(ready), 1);
    chk("reset_valid", int'(pix_valid), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_xy", int'({pix_x, pix_y}), 0);
    chk("reset_colour", int'(pix_colour), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i].rq, 1'b0, 1'b0);
      chk($sformatf("vec%0d_beats", i), got_q.size(), vecs[i].beats);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      if (got_q.size() > 0) begin
        chk($sformatf("vec%0d_first_x", i), int'(got_q[0].x), vecs[i].fx);
        chk($sformatf("vec%0d_first_y", i), int'(got_q[0].y), vecs[i].fy);
        chk($sformatf("vec%0d_first_colour", i), int'(got_q[0].col), vecs[i].fcol);
        chk($sformatf("vec%0d_last_x", i), int'(got_q[$].x), vecs[i].lx);
        chk($sformatf("vec%0d_last_y", i), int'(got_q[$].y), vecs[i].ly);
        chk($sformatf("vec%0d_last_colour", i), int'(got_q[$].col), vecs[i].lcol);
      end else begin
        chk($sformatf("vec%0d_beats_present", i), 0, 1);
      end
      if (vecs[i].rq.opq) begin
        found = -1;
        foreach (got_q[k]) if (got_q[k].x == 8'd24 && got_q[k].y == 8'd35) found = int'(got_q[k].col);
        chk($sformatf("vec%0d_colour_24_35", i), found, 63);
      end
      if (vecs[i].beats == 24 && vecs[i].rq.scale == 1) begin
        if (got_q.size() > 1) begin
          chk("second_beat_x", int'(got_q[1].x), 27);
          chk("second_beat_y", int'(got_q[1].y), 30);
        end else begin
          chk("second_beat_present", 0, 1);
        end
      end
    end

    // Opaque glyph with random back-pressure and start pulsed while busy.
    rq = vecs[1].rq;
    run_req(rq, 1'b1, 1'b1);
    chk("stall_run_beats", got_q.size(), 100);

    for (int n = 0; n < 10; n++) begin
      rq.code  = 0;
      rq.ox    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(230, 255)) : int'($urandom_range(0, 255));
      rq.oy    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(230, 255)) : int'($urandom_range(0, 255));
      rq.fg    = int'($urandom_range(0, 63));
      rq.bg    = int'($urandom_range(0, 63));
      rq.opq   = 1'($urandom_range(0, 1));
      rq.scale = int'($urandom_range(0, 3));
      run_req(rq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset asserted while a beat is stalled.
    rq = vecs[1].rq;
    drive(rq);
    start = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    pix_ready = 1'b0;
    waited    = 0;
    @(negedge clock);
    while (!pix_valid && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk("valid_before_reset", int'(pix_valid), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_valid", int'(pix_valid), 0);
    chk("async_reset_ready", int'(ready), 1);
    chk("async_reset_done", int'(done), 0);
    chk("async_reset_xy", int'({pix_x, pix_y}), 0);
    chk("async_reset_colour", int'(pix_colour), 0);
    @(posedge clock);
    @(negedge clock);
    resetn    = 1'b1;
    pix_ready = 1'b1;
    run_req(vecs[0].rq, 1'b0, 1'b0);
    chk("post_reset_beats", got_q.size(), 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
